ecc_result_checker: RTL and testbench

ECC_RESULT_CHECKER -- requirements
Module: ecc_result_checker

---
 rtl/ecc_chk_pkg.sv | 38 +++
 rtl/ecc_chk_fifo.sv | 54 +++++
 rtl/ecc_result_checker.sv | 157 +++++++++++++++
 tb/tb_ecc_result_checker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_chk_pkg.sv
// Shared types and constants for the ECC result checker: golden-entry modes,
// compare-width codes, checker FSM states and the width-to-mask table.
package ecc_chk_pkg;

  typedef enum logic [1:0] {
    ENCODE       = 2'd0,
    DECODE       = 2'd1,
    FULL_CHANNEL = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    CW_8      = 2'd0,
    CW_16     = 2'd1,
    CW_32     = 2'd2,
    CW_32_ALT = 2'd3
  } code_width_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [31:0] MASK_8  = 32'h0000_00FF;
  localparam logic [31:0] MASK_16 = 32'h0000_FFFF;
  localparam logic [31:0] MASK_32 = 32'hFFFF_FFFF;

  // Code 3 is not a real width; it compares like the full 32-bit word.
  function automatic logic [31:0] cw_mask(input logic [1:0] cw);
    case (cw)
      CW_8:    return MASK_8;
      CW_16:   return MASK_16;
      default: return MASK_32;
    endcase
  endfunction

endpackage

// File: rtl/ecc_chk_fifo.sv
// Synchronous golden-entry queue: power-of-two depth, show-ahead head output.
// Storage is not reset; only pointers and occupancy are.
module ecc_chk_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Entry storage, written on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ecc_result_checker.sv
// ECC result checker: queues golden results, compares each against the DUT
// output one cycle after a rising edge of operation_done, and keeps per-mode
// saturating hit/miss counters plus a capture of the first mismatch.
// Optional build macro ECC_CHK_HALT_ON_MISS_EN freezes the checker on the first miss.
module ecc_result_checker
  import ecc_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    gold_valid,
  output logic                    gold_ready,
  input  logic [DATA_WIDTH-1:0]   gold_data,
  input  logic [1:0]              gold_errs,
  input  logic [1:0]              gold_mode,
  input  logic [1:0]              code_width,
  input  logic                    operation_done,
  input  logic [DATA_WIDTH-1:0]   dut_data,
  input  logic [1:0]              dut_errs,
  output logic [3*CNT_WIDTH-1:0]  hit_cnt,
  output logic [3*CNT_WIDTH-1:0]  miss_cnt,
  output logic                    mismatch_valid,
  output logic [DATA_WIDTH+1:0]   mismatch_gold,
  output logic [DATA_WIDTH+1:0]   mismatch_dut,
  output logic                    underflow,
  output logic                    halted
);

  localparam int ENTRY_W = DATA_WIDTH + 4;
  localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;

  state_e                state, state_nxt;
  logic                  done_p1;
  logic                  done_edge;
  logic                  push, pop, full, empty;
  logic [OCC_W-1:0]      count;
  logic [ENTRY_W-1:0]    head;
  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            head_errs;
  logic [1:0]            head_mode;
  logic                  mode_ok;
  logic [31:0]           m32;
  logic [DATA_WIDTH-1:0] mask;
  logic                  hit;
  logic                  set_underflow;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign done_edge  = operation_done && !done_p1;
  assign gold_ready = !full && (state != HALT);
  assign push       = gold_valid && gold_ready;
  assign pop        = (state == CHECK);
  assign head_data  = head[DATA_WIDTH-1:0];
  assign head_errs  = head[DATA_WIDTH+1:DATA_WIDTH];
  assign head_mode  = head[DATA_WIDTH+3:DATA_WIDTH+2];
  assign mode_ok    = (head_mode != 2'd3);

`ifdef ECC_CHK_HALT_ON_MISS_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  ecc_chk_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .push    (push),
    .pop     (pop),
    .wr_data ({gold_mode, gold_errs, gold_data}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Compare queue head against the live DUT outputs under the width mask.
  always_comb begin
    m32  = cw_mask(code_width);
    mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) mask[i] = (i < 32) ? m32[i[4:0]] : 1'b0;
    if (head_mode == ENCODE)
      hit = (((head_data ^ dut_data) & mask) == '0);
    else
      hit = ((((head_data ^ dut_data) & mask) == '0) && (head_errs == dut_errs)) ||
            ((head_errs == 2'd2) && (dut_errs == 2'd2));
  end

  // Next-state logic: arm on push, check on done edge, flag done with nothing queued.
  always_comb begin
    state_nxt     = state;
    set_underflow = 1'b0;
    case (state)
      IDLE: begin
        if (done_edge) set_underflow = 1'b1;
        if (push)      state_nxt     = ARMED;
      end
      ARMED: begin
        if (done_edge && !empty) state_nxt = CHECK;
      end
      CHECK: begin
        if ((count == OCC_W'(1)) && !push) state_nxt = IDLE;
        else                               state_nxt = ARMED;
`ifdef ECC_CHK_HALT_ON_MISS_EN
        if (mode_ok && !hit) state_nxt = HALT;
`endif
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // State, done-edge history and sticky underflow.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      done_p1   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_p1 <= operation_done;
      if (set_underflow) underflow <= 1'b1;
    end
  end

  // Result bookkeeping in the CHECK cycle: counters and first-miss capture.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      hit_cnt        <= '0;
      miss_cnt       <= '0;
      mismatch_valid <= 1'b0;
      mismatch_gold  <= '0;
      mismatch_dut   <= '0;
    end else if ((state == CHECK) && mode_ok) begin
      if (hit) begin
        hit_cnt[int'(head_mode)*CNT_WIDTH +: CNT_WIDTH] <=
          sat_inc(hit_cnt[int'(head_mode)*CNT_WIDTH +: CNT_WIDTH]);
      end else begin
        miss_cnt[int'(head_mode)*CNT_WIDTH +: CNT_WIDTH] <=
          sat_inc(miss_cnt[int'(head_mode)*CNT_WIDTH +: CNT_WIDTH]);
        if (!mismatch_valid) begin
          mismatch_valid <= 1'b1;
          mismatch_gold  <= {head_errs, head_data};
          mismatch_dut   <= {dut_errs, dut_data};
        end
      end
    end
  end

endmodule

// File: tb/tb_ecc_result_checker.sv
// Directed bench for ecc_result_checker: a vector table of single transactions
// followed by hand-written multi-cycle sequences (full queue, underflow,
// held done, push with done edge, halt behaviour, reset mid-check).
module tb_ecc_result_checker;
  import ecc_chk_pkg::*;

  localparam int DW = 32;
  localparam int FD = 16;
  localparam int CW = 4;
`ifdef ECC_CHK_HALT_ON_MISS_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic              gold_valid = 1'b0;
  logic              gold_ready;
  logic [DW-1:0]     gold_data = '0;
  logic [1:0]        gold_errs = '0;
  logic [1:0]        gold_mode = '0;
  logic [1:0]        code_width = '0;
  logic              operation_done = 1'b0;
  logic [DW-1:0]     dut_data = '0;
  logic [1:0]        dut_errs = '0;
  logic [3*CW-1:0]   hit_cnt;
  logic [3*CW-1:0]   miss_cnt;
  logic              mismatch_valid;
  logic [DW+1:0]     mismatch_gold;
  logic [DW+1:0]     mismatch_dut;
  logic              underflow;
  logic              halted;

  int n_cmp = 0;
  int n_bad = 0;

  ecc_result_checker #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .CNT_WIDTH  (CW)
  ) dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .gold_valid     (gold_valid),
    .gold_ready     (gold_ready),
    .gold_data      (gold_data),
    .gold_errs      (gold_errs),
    .gold_mode      (gold_mode),
    .code_width     (code_width),
    .operation_done (operation_done),
    .dut_data       (dut_data),
    .dut_errs       (dut_errs),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt),
    .mismatch_valid (mismatch_valid),
    .mismatch_gold  (mismatch_gold),
    .mismatch_dut   (mismatch_dut),
    .underflow      (underflow),
    .halted         (halted)
  );

  initial forever #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  gerrs;
    logic [31:0] gdata;
    logic [1:0]  cw;
    logic [1:0]  derrs;
    logic [31:0] ddata;
    bit          hit;
  } vec_t;

  vec_t vecs[12];
  int   hit_m[3];
  int   miss_m[3];
  bit   halted_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] hc(input int m);
    return hit_cnt[m*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] mc(input int m);
    return miss_cnt[m*CW +: CW];
  endfunction

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    gold_valid     = 1'b0;
    operation_done = 1'b0;
    PRESETn        = 1'b0;
    step();
    step();
    PRESETn        = 1'b1;
  endtask

  task automatic push(input logic [1:0] mode, input logic [1:0] errs, input logic [31:0] data);
    gold_mode  = mode;
    gold_errs  = errs;
    gold_data  = data;
    gold_valid = 1'b1;
    step();
    gold_valid = 1'b0;
  endtask

  task automatic done_pulse(input logic [1:0] cw, input logic [1:0] errs, input logic [31:0] data);
    code_width     = cw;
    dut_errs       = errs;
    dut_data       = data;
    operation_done = 1'b1;
    step();
    operation_done = 1'b0;
    step();
  endtask

  initial begin
    vecs[0]  = '{ENCODE,       2'd0, 32'h0000_00A5, 2'd0, 2'd0, 32'h0000_01A5, 1'b1};
    vecs[1]  = '{DECODE,       2'd1, 32'h0000_1234, 2'd1, 2'd0, 32'h0000_1234, 1'b0};
    vecs[2]  = '{FULL_CHANNEL, 2'd2, 32'h0000_0000, 2'd2, 2'd2, 32'h0000_FFFF, 1'b1};
    vecs[3]  = '{ENCODE,       2'd3, 32'h1234_5678, 2'd2, 2'd0, 32'h1234_5678, 1'b1};
    vecs[4]  = '{ENCODE,       2'd0, 32'h1234_5678, 2'd1, 2'd0, 32'hABCD_5678, 1'b1};
    vecs[5]  = '{ENCODE,       2'd0, 32'h1234_5678, 2'd1, 2'd0, 32'h1234_5679, 1'b0};
    vecs[6]  = '{DECODE,       2'd1, 32'hDEAD_00FF, 2'd0, 2'd1, 32'h0000_00FF, 1'b1};
    vecs[7]  = '{DECODE,       2'd2, 32'h0000_0001, 2'd2, 2'd2, 32'h0000_0002, 1'b1};
    vecs[8]  = '{FULL_CHANNEL, 2'd2, 32'h0000_0005, 2'd2, 2'd1, 32'h0000_0005, 1'b0};
    vecs[9]  = '{FULL_CHANNEL, 2'd0, 32'hCAFE_BABE, 2'd3, 2'd0, 32'hCAFE_BABE, 1'b1};
    vecs[10] = '{FULL_CHANNEL, 2'd0, 32'hCAFE_BABE, 2'd3, 2'd0, 32'h4AFE_BABE, 1'b0};
    vecs[11] = '{DECODE,       2'd1, 32'h0000_FFFF, 2'd1, 2'd1, 32'h0001_FFFF, 1'b1};
    for (int m = 0; m < 3; m++) begin
      hit_m[m]  = 0;
      miss_m[m] = 0;
    end
    halted_m = 1'b0;

    // Reset state
    do_reset();
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    check("rst_gold_ready", 64'(gold_ready), 64'd1);
    check("rst_mismatch_valid", 64'(mismatch_valid), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // Vector table: one push and one done pulse per record
    for (int i = 0; i < 12; i++) begin
      push(vecs[i].mode, vecs[i].gerrs, vecs[i].gdata);
      done_pulse(vecs[i].cw, vecs[i].derrs, vecs[i].ddata);
      if (!halted_m) begin
        if (vecs[i].hit) hit_m[vecs[i].mode]++;
        else begin
          miss_m[vecs[i].mode]++;
          if (HALT_EN) halted_m = 1'b1;
        end
      end
      check($sformatf("vec%0d_hit", i), 64'(hc(int'(vecs[i].mode))), 64'(hit_m[vecs[i].mode]));
      check($sformatf("vec%0d_miss", i), 64'(mc(int'(vecs[i].mode))), 64'(miss_m[vecs[i].mode]));
      check($sformatf("vec%0d_ready", i), 64'(gold_ready), 64'(!halted_m));
      check($sformatf("vec%0d_halted", i), 64'(halted), 64'(halted_m));
    end
    check("first_mm_valid", 64'(mismatch_valid), 64'd1);
    check("first_mm_gold", 64'(mismatch_gold), {30'd0, 2'd1, 32'h0000_1234});
    check("first_mm_dut", 64'(mismatch_dut), {30'd0, 2'd0, 32'h0000_1234});
    check("tbl_underflow", 64'(underflow), 64'd0);

    // Fill the queue, try a 17th push, drain with 16 matching checks
    do_reset();
    gold_mode  = ENCODE;
    gold_errs  = 2'd0;
    gold_valid = 1'b1;
    for (int i = 0; i < FD; i++) begin
      gold_data = 32'(i);
      step();
    end
    check("full_ready_low", 64'(gold_ready), 64'd0);
    gold_data = 32'h99;
    step();
    gold_valid = 1'b0;
    for (int i = 0; i < FD; i++) done_pulse(2'd2, 2'd0, 32'(i));
    check("full_hit_saturated", 64'(hc(0)), 64'd15);
    check("full_miss", 64'(mc(0)), 64'd0);
    check("full_ready_back", 64'(gold_ready), 64'd1);
    check("full_no_underflow", 64'(underflow), 64'd0);
    done_pulse(2'd2, 2'd0, 32'h99);
    check("full_17th_dropped", 64'(underflow), 64'd1);
    check("full_17th_hit", 64'(hc(0)), 64'd15);

    // Done with empty queue, then a held-high done must count only once
    do_reset();
    operation_done = 1'b1;
    step();
    step();
    step();
    check("uf_set", 64'(underflow), 64'd1);
    check("uf_hit", 64'(hit_cnt), 64'd0);
    check("uf_miss", 64'(miss_cnt), 64'd0);
    code_width = 2'd0;
    dut_data   = 32'h77;
    dut_errs   = 2'd0;
    push(ENCODE, 2'd0, 32'h77);
    step();
    step();
    check("held_no_compare", 64'(hit_cnt), 64'd0);
    operation_done = 1'b0;
    step();
    done_pulse(2'd0, 2'd0, 32'h77);
    check("held_then_pulse_hit", 64'(hc(0)), 64'd1);

    // Push into empty queue in the same cycle as a done edge
    do_reset();
    gold_mode      = ENCODE;
    gold_errs      = 2'd0;
    gold_data      = 32'h3C;
    gold_valid     = 1'b1;
    operation_done = 1'b1;
    step();
    gold_valid     = 1'b0;
    operation_done = 1'b0;
    step();
    check("pushdone_underflow", 64'(underflow), 64'd1);
    check("pushdone_no_hit", 64'(hit_cnt), 64'd0);
    done_pulse(2'd0, 2'd0, 32'h3C);
    check("pushdone_kept_hit", 64'(hc(0)), 64'd1);

    // Miss followed by an entry that would hit
    do_reset();
    push(DECODE, 2'd0, 32'h10);
    push(ENCODE, 2'd0, 32'h20);
    done_pulse(2'd2, 2'd0, 32'h11);
    check("halt_miss_cnt", 64'(mc(1)), 64'd1);
    check("halt_flag", 64'(halted), 64'(HALT_EN));
    check("halt_ready", 64'(gold_ready), 64'(!HALT_EN));
    done_pulse(2'd2, 2'd0, 32'h20);
    check("halt_hit_after_miss", 64'(hc(0)), HALT_EN ? 64'd0 : 64'd1);

    // Reset asserted while in CHECK discards the pending comparison
    do_reset();
    push(DECODE, 2'd0, 32'h55);
    code_width     = 2'd2;
    dut_data       = 32'h66;
    dut_errs       = 2'd0;
    operation_done = 1'b1;
    step();
    PRESETn = 1'b0;
    #1;
    check("midchk_hit", 64'(hit_cnt), 64'd0);
    check("midchk_miss", 64'(miss_cnt), 64'd0);
    check("midchk_mm_valid", 64'(mismatch_valid), 64'd0);
    check("midchk_mm_gold", 64'(mismatch_gold), 64'd0);
    check("midchk_mm_dut", 64'(mismatch_dut), 64'd0);
    check("midchk_halted", 64'(halted), 64'd0);
    check("midchk_ready", 64'(gold_ready), 64'd1);
    operation_done = 1'b0;
    step();
    PRESETn = 1'b1;
    step();
    check("midchk_after_miss", 64'(miss_cnt), 64'd0);
    done_pulse(2'd2, 2'd0, 32'h55);
    check("midchk_queue_cleared", 64'(underflow), 64'd1);
    check("midchk_queue_hit", 64'(hit_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
